// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port, byte-addressed RAM between an instruction-fetch requester (I, read
//   only) and a load/store requester (D). Only one transaction is outstanding at a time. Each
//   accepted request is classified as one of three kinds:
//   - console print: a D store to PRINT_ADDR, which pulses the print port;
//   - error: illegal mask, out of range, or misaligned;
//   - RAM access: a fixed-latency memory access.
//   The response is then held on the winner's response port until that requester consumes it.
//
// Ports
//   clk_i, rst                 clock (rising edge), synchronous active-high reset
//   i_valid_i/i_ready_o        I request handshake; i_addr_i is the byte address
//   i_rvalid_o/i_rready_i      I response handshake; i_rdata_o, i_err_o
//   d_valid_i/d_ready_o        D request handshake; d_addr_i, d_we_i (byte mask), d_wdata_i
//   d_rvalid_o/d_rready_i      D response handshake; d_rdata_o, d_err_o
//   mem_en_o, mem_we_o,        RAM strobe (one cycle per access), lane write mask, byte offset,
//   mem_addr_o, mem_wdata_o    write data
//   mem_rdata_i                RAM read data, valid MEM_LATENCY cycles after mem_en_o
//   print_valid_o/print_data_o one-cycle console strobe and character
module ram_port_arbiter #(
  parameter logic [31:0] START_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_SIZE     = 65536,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter logic [31:0] PRINT_ADDR   = 32'h8000_1000,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst,
  // Instruction-fetch requester
  input  logic        i_valid_i,
  output logic        i_ready_o,
  input  logic [31:0] i_addr_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        i_rready_i,
  // Load/store requester
  input  logic        d_valid_i,
  output logic        d_ready_o,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_we_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  input  logic        d_rready_i,
  // RAM port
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  // Console port
  output logic        print_valid_o,
  output logic [7:0]  print_data_o
);

  localparam int unsigned CntW   = $clog2(MEM_LATENCY + 1);
  localparam int unsigned StrkW  = $clog2(MAX_D_STREAK + 2);
  localparam logic [31:0] MaxOff = 32'(MEM_SIZE - 4);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              owner_d_q, owner_d_d;  // 1: D owns the transaction, 0: I
  logic [StrkW-1:0]  streak_q, streak_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              print_valid_q, print_valid_d;
  logic [7:0]        print_data_q, print_data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              grant_d, grant_i;
  logic [31:0]       req_addr, req_off, req_wdata;
  logic [3:0]        req_we;
  logic              we_legal, is_print, is_err;

  // Arbitration. Grants are suppressed while rst is high so that no requester sees a
  // handshake that the reset is about to discard.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == StIdle && !rst) begin
      grant_d = d_valid_i && !(i_valid_i && streak_q == StrkW'(MAX_D_STREAK));
      grant_i = i_valid_i && !grant_d;
    end
  end

  // Starvation guard: counts D grants taken while I was waiting.
  always_comb begin
    streak_d = streak_q;
    if (grant_i || !i_valid_i) begin
      streak_d = '0;
    end else if (grant_d && streak_q != StrkW'(MAX_D_STREAK)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Winner's request and its classification
  always_comb begin
    req_addr  = grant_d ? d_addr_i : i_addr_i;
    req_we    = grant_d ? d_we_i : 4'b0000;
    req_wdata = grant_d ? d_wdata_i : 32'h0;
    req_off   = req_addr - START_ADDR;
    we_legal  = (req_we == 4'b0000) || (req_we == 4'b0001) ||
                (req_we == 4'b0011) || (req_we == 4'b1111);
    is_print  = grant_d && (req_we != 4'b0000) && (req_addr == PRINT_ADDR);
    // Alignment is judged on the absolute address, range on the RAM offset.
    is_err    = !we_legal || (req_off > MaxOff) ||
                (((req_we == 4'b1111) || (req_we == 4'b0000)) && (req_addr[1:0] != 2'b00)) ||
                ((req_we == 4'b0011) && req_addr[0]);
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    owner_d_d     = owner_d_q;
    cnt_d         = cnt_q;
    mem_en_d      = 1'b0;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    print_valid_d = 1'b0;
    print_data_d  = print_data_q;
    rdata_d       = rdata_q;
    err_d         = err_q;

    unique case (state_q)
      StIdle: begin
        if (grant_d || grant_i) begin
          owner_d_d = grant_d;
          rdata_d   = 32'h0;
          err_d     = 1'b0;
          cnt_d     = '0;
          if (is_print) begin
            print_valid_d = 1'b1;
            print_data_d  = req_wdata[7:0];
            state_d       = StResp;
          end else if (is_err) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            mem_en_d    = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_off;
            mem_wdata_d = req_wdata;
            state_d     = StAccess;
          end
        end
      end
      StAccess: begin
        // cnt_q is 0 in the mem_en cycle, so it equals MEM_LATENCY when read data is valid.
        if (cnt_q == CntW'(MEM_LATENCY)) begin
          if (mem_we_q == 4'b0000) begin
            rdata_d = mem_rdata_i;
          end
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (owner_d_q ? d_rready_i : i_rready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q       <= StIdle;
      owner_d_q     <= 1'b0;
      streak_q      <= '0;
      cnt_q         <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 4'b0000;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      print_valid_q <= 1'b0;
      print_data_q  <= 8'h00;
      rdata_q       <= 32'h0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_d_q     <= owner_d_d;
      streak_q      <= streak_d;
      cnt_q         <= cnt_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      print_valid_q <= print_valid_d;
      print_data_q  <= print_data_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end

  // Outputs: only the owner's response port is ever active.
  logic resp;
  always_comb begin
    resp          = (state_q == StResp);
    i_ready_o     = grant_i;
    d_ready_o     = grant_d;
    i_rvalid_o    = resp && !owner_d_q;
    d_rvalid_o    = resp && owner_d_q;
    i_rdata_o     = i_rvalid_o ? rdata_q : 32'h0;
    d_rdata_o     = d_rvalid_o ? rdata_q : 32'h0;
    i_err_o       = i_rvalid_o && err_q;
    d_err_o       = d_rvalid_o && err_q;
    mem_en_o      = mem_en_q;
    mem_we_o      = mem_en_q ? mem_we_q : 4'b0000;
    mem_addr_o    = mem_addr_q;
    mem_wdata_o   = mem_wdata_q;
    print_valid_o = print_valid_q;
    print_data_o  = print_data_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam logic [31:0] START_ADDR = 32'h0000_0000;
  localparam int unsigned MEM_SIZE   = 65536;
  localparam int unsigned LAT        = 1;
  localparam logic [31:0] PRINT_ADDR = 32'h8000_1000;
  localparam int unsigned MAX_D      = 4;
  localparam int KAcc = 0, KErr = 1, KPrint = 2;

  logic clk_i = 1'b0;
  logic rst = 1'b1;
  logic i_valid_i = 0, i_rready_i = 0, d_valid_i = 0, d_rready_i = 0;
  logic [31:0] i_addr_i = 0, d_addr_i = 0, d_wdata_i = 0;
  logic [3:0]  d_we_i = 0;
  logic i_ready_o, i_rvalid_o, i_err_o, d_ready_o, d_rvalid_o, d_err_o;
  logic [31:0] i_rdata_o, d_rdata_o;
  logic mem_en_o, print_valid_o;
  logic [3:0] mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0] print_data_o;

  always #5 clk_i = ~clk_i;

  ram_port_arbiter #(
    .START_ADDR(START_ADDR), .MEM_SIZE(MEM_SIZE), .MEM_LATENCY(LAT),
    .PRINT_ADDR(PRINT_ADDR), .MAX_D_STREAK(MAX_D)
  ) dut (
    .clk_i(clk_i), .rst(rst),
    .i_valid_i(i_valid_i), .i_ready_o(i_ready_o), .i_addr_i(i_addr_i),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o), .i_rready_i(i_rready_i),
    .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
    .d_wdata_i(d_wdata_i), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .d_rready_i(d_rready_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .print_valid_o(print_valid_o), .print_data_o(print_data_o)
  );

  function automatic int ix(input logic [31:0] a, input int k);
    return int'((a + 32'(k)) & 32'(MEM_SIZE - 1));
  endfunction

  // RAM array driven by the DUT; returns garbage except exactly LAT=1 cycle after mem_en.
  logic [7:0] ram [MEM_SIZE];
  logic [7:0] ref_mem [MEM_SIZE];
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      for (int k = 0; k < 4; k++)
        if (mem_we_o[k]) ram[ix(mem_addr_o, k)] <= mem_wdata_o[8*k +: 8];
      mem_rdata_i <= {ram[ix(mem_addr_o, 3)], ram[ix(mem_addr_o, 2)],
                      ram[ix(mem_addr_o, 1)], ram[ix(mem_addr_o, 0)]};
    end else begin
      mem_rdata_i <= $urandom();
    end
  end

  int tests = 0, fails = 0, cyc = 0;
  int n_men = 0, n_pv = 0;
  logic [7:0] last_pd = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level reference model plus per-cycle compare.
  bit live = 0, m_busy = 0, m_is_d = 0;
  int m_kind = 0, m_acc = 0, m_resp = 0, m_streak = 0;
  logic [31:0] m_off = 0, m_wd = 0, m_rd = 0;
  logic [3:0] m_we = 0;
  logic m_err = 0;
  logic [7:0] m_pd = 0;

  always @(negedge clk_i) begin
    bit gd, gi, e_men, e_pv, e_resp, legal, bad;
    logic [31:0] a;
    logic [3:0] w;
    #3;
    if (rst) begin
      m_busy = 0; m_streak = 0; live = 1;
    end else if (live) begin
      if (mem_en_o) n_men++;
      if (print_valid_o) begin n_pv++; last_pd = print_data_o; end
      gd = 0; gi = 0;
      if (!m_busy) begin
        gd = d_valid_i && !(i_valid_i && m_streak == MAX_D);
        gi = i_valid_i && !gd;
      end
      e_men  = m_busy && m_kind == KAcc && cyc == m_acc + 1;
      e_pv   = m_busy && m_kind == KPrint && cyc == m_acc + 1;
      e_resp = m_busy && cyc >= m_resp;
      chk("i_ready", i_ready_o, gi);
      chk("d_ready", d_ready_o, gd);
      chk("mem_en", mem_en_o, e_men);
      chk("print_valid", print_valid_o, e_pv);
      chk("i_rvalid", i_rvalid_o, e_resp && !m_is_d);
      chk("d_rvalid", d_rvalid_o, e_resp && m_is_d);
      if (e_men) begin
        chk("mem_addr", mem_addr_o, m_off);
        chk("mem_we", mem_we_o, m_we);
        if (m_we != 0) chk("mem_wdata", mem_wdata_o, m_wd);
        for (int k = 0; k < 4; k++) if (m_we[k]) ref_mem[ix(m_off, k)] = m_wd[8*k +: 8];
      end
      if (e_pv) chk("print_data", print_data_o, m_pd);
      if (e_resp && !m_is_d) begin
        chk("i_rdata", i_rdata_o, m_rd); chk("i_err", i_err_o, m_err);
      end
      if (e_resp && m_is_d) begin
        chk("d_rdata", d_rdata_o, m_rd); chk("d_err", d_err_o, m_err);
      end
      if (e_resp && (m_is_d ? d_rready_i : i_rready_i)) m_busy = 0;
      if (gi || !i_valid_i) m_streak = 0;
      else if (gd && m_streak < MAX_D) m_streak++;
      if (gd || gi) begin
        a = gd ? d_addr_i : i_addr_i;
        w = gd ? d_we_i : 4'h0;
        m_busy = 1; m_is_d = gd; m_acc = cyc; m_off = a - START_ADDR;
        m_we = w; m_wd = d_wdata_i; m_err = 0; m_rd = 0;
        legal = (w == 4'h0) || (w == 4'h1) || (w == 4'h3) || (w == 4'hF);
        bad = !legal || (m_off > 32'(MEM_SIZE - 4)) ||
              ((w == 4'h0 || w == 4'hF) && a[1:0] != 0) || (w == 4'h3 && a[0]);
        if (gd && w != 0 && a == PRINT_ADDR) begin
          m_kind = KPrint; m_pd = d_wdata_i[7:0]; m_resp = cyc + 1;
        end else if (bad) begin
          m_kind = KErr; m_err = 1; m_resp = cyc + 1;
        end else begin
          m_kind = KAcc; m_resp = cyc + 2 + LAT;
          if (w == 0) m_rd = {ref_mem[ix(m_off, 3)], ref_mem[ix(m_off, 2)],
                              ref_mem[ix(m_off, 1)], ref_mem[ix(m_off, 0)]};
        end
      end
    end
  end

  // One blocking request/response; lat = response cycle minus accept cycle.
  task automatic issue(input bit is_d, input logic [31:0] addr, input logic [3:0] we,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
    int t_acc;
    bit got;
    t_acc = 0; rd = 32'hx; er = 1'bx; lat = -1; got = 0;
    @(negedge clk_i);
    i_rready_i = 1; d_rready_i = 1;
    if (is_d) begin d_valid_i = 1; d_addr_i = addr; d_we_i = we; d_wdata_i = wd; end
    else begin i_valid_i = 1; i_addr_i = addr; end
    for (int k = 0; k < 64; k++) begin
      #4;
      if (is_d ? d_ready_o : i_ready_o) begin got = 1; t_acc = cyc; break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    i_valid_i = 0; d_valid_i = 0;
    if (!got) begin
      tests++; fails++; $display("FAIL accept_timeout: no ready within 64 cycles");
      return;
    end
    got = 0;
    for (int k = 0; k < 64; k++) begin
      #4;
      if (is_d ? d_rvalid_o : i_rvalid_o) begin
        got = 1; lat = cyc - t_acc;
        rd = is_d ? d_rdata_o : i_rdata_o; er = is_d ? d_err_o : i_err_o;
        break;
      end
      @(negedge clk_i);
    end
    if (!got) begin
      tests++; fails++; $display("FAIL resp_timeout: no rvalid within 64 cycles");
    end
  endtask

  task automatic run_both();
    string seq;
    int ni, nd;
    seq = ""; ni = 0; nd = 0;
    i_rready_i = 1; d_rready_i = 1;
    for (int c = 0; c < 400 && (ni < 10 || nd < 10); c++) begin
      @(negedge clk_i);
      i_valid_i = (ni < 10); i_addr_i = 32'h100 + 32'(ni * 4);
      d_valid_i = (nd < 10); d_addr_i = 32'h200 + 32'(nd * 4); d_we_i = 4'h0;
      #4;
      if (i_valid_i && i_ready_o) begin seq = {seq, "I"}; ni++; end
      if (d_valid_i && d_ready_o) begin seq = {seq, "D"}; nd++; end
    end
    @(negedge clk_i);
    i_valid_i = 0; d_valid_i = 0;
    tests++;
    if (seq != "DDDDIDDDDIDDIIIIIIII") begin
      fails++;
      $display("FAIL grant_order: got %s expected DDDDIDDDDIDDIIIIIIII", seq);
    end
    repeat (8) @(negedge clk_i);
  endtask

  function automatic logic [31:0] rnd_i_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return $urandom();
    if (r == 1) return 32'($urandom_range(0, 255));
    if (r == 2) return 32'(MEM_SIZE) - 32'($urandom_range(0, 8));
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  task automatic rnd_d(output logic [31:0] a, output logic [3:0] w, output logic [31:0] wd);
    int r = $urandom_range(0, 9);
    int r2 = $urandom_range(0, 9);
    if (r < 3) w = 4'h0;
    else if (r < 5) w = 4'h1;
    else if (r < 7) w = 4'h3;
    else if (r < 9) w = 4'hF;
    else w = 4'($urandom_range(0, 15));
    if (r2 == 0) a = PRINT_ADDR;
    else if (r2 == 1) a = $urandom();
    else if (r2 == 2) a = 32'(MEM_SIZE) - 32'($urandom_range(0, 8));
    else begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (w == 4'h0 || w == 4'hF) a[1:0] = 2'b00;
        if (w == 4'h3) a[0] = 1'b0;
      end
    end
    wd = $urandom();
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, men0, pv0;
    bit got, i_fire, d_fire;
    logic [31:0] ta, twd;
    logic [3:0] tw;

    for (int i = 0; i < MEM_SIZE; i++) begin
      ram[i] <= 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    ram[16'h10] <= 8'h78; ram[16'h11] <= 8'h56; ram[16'h12] <= 8'h34; ram[16'h13] <= 8'h12;
    ram[16'h20] <= 8'h11; ram[16'h21] <= 8'h22; ram[16'h22] <= 8'h33; ram[16'h23] <= 8'h44;
    ref_mem[16'h10] = 8'h78; ref_mem[16'h11] = 8'h56;
    ref_mem[16'h12] = 8'h34; ref_mem[16'h13] = 8'h12;
    ref_mem[16'h20] = 8'h11; ref_mem[16'h21] = 8'h22;
    ref_mem[16'h22] = 8'h33; ref_mem[16'h23] = 8'h44;

    repeat (3) @(negedge clk_i);
    rst = 0;
    @(negedge clk_i);
    #4;
    chk("reset_outputs", 32'({i_ready_o, d_ready_o, i_rvalid_o, d_rvalid_o, mem_en_o,
                              print_valid_o, |i_rdata_o, |d_rdata_o, |mem_addr_o}), 32'h0);

    issue(0, 32'h10, 4'h0, 0, rd, er, lat);
    chk("iread_data", rd, 32'h1234_5678); chk("iread_err", er, 0); chk("iread_lat", lat, 3);

    run_both();

    issue(1, 32'h22, 4'h3, 32'h0000_BEEF, rd, er, lat);
    chk("half_store_rdata", rd, 0); chk("half_store_err", er, 0);
    issue(1, 32'h20, 4'h0, 0, rd, er, lat);
    chk("half_store_readback", rd, 32'hBEEF_2211); chk("readback_err", er, 0);

    men0 = n_men; pv0 = n_pv;
    issue(1, PRINT_ADDR, 4'h1, 32'h0000_0041, rd, er, lat);
    @(negedge clk_i);
    chk("print_pulses", n_pv - pv0, 1); chk("print_char", last_pd, 8'h41);
    chk("print_no_mem", n_men - men0, 0); chk("print_err", er, 0);

    men0 = n_men;
    issue(1, 32'h0001_0000, 4'h0, 0, rd, er, lat);
    chk("oor_err", er, 1); chk("oor_rdata", rd, 0); chk("oor_lat", lat, 1);
    issue(0, 32'h6, 4'h0, 0, rd, er, lat);
    chk("misalign_err", er, 1); chk("misalign_rdata", rd, 0);
    issue(1, 32'h40, 4'h5, 32'hFFFF_FFFF, rd, er, lat);
    chk("badwe_err", er, 1); chk("badwe_rdata", rd, 0);
    chk("err_no_mem", n_men - men0, 0);

    // Reset while the RAM access is in flight
    @(negedge clk_i);
    i_valid_i = 1; i_addr_i = 32'h10; got = 0;
    for (int k = 0; k < 64; k++) begin
      #4;
      if (i_ready_o) begin got = 1; break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    i_valid_i = 0; rst = 1;
    #4;
    chk("rst_accept_seen", 32'(got), 1);
    chk("rst_mid_mem_en", mem_en_o, 1);
    @(negedge clk_i);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk("post_rst_quiet", 32'({i_rvalid_o, d_rvalid_o, mem_en_o, print_valid_o, |mem_we_o,
                                 |mem_addr_o, |mem_wdata_o, |i_rdata_o, i_err_o}), 32'h0);
      @(negedge clk_i);
    end
    issue(0, 32'h10, 4'h0, 0, rd, er, lat);
    chk("post_rst_read", rd, 32'h1234_5678); chk("post_rst_lat", lat, 3);

    // Randomized traffic; requesters hold payload until accepted.
    i_fire = 0; d_fire = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk_i);
      if (!i_valid_i || i_fire) begin
        i_valid_i = ($urandom_range(0, 2) != 0); i_addr_i = rnd_i_addr();
      end
      if (!d_valid_i || d_fire) begin
        d_valid_i = ($urandom_range(0, 2) != 0);
        rnd_d(ta, tw, twd);
        d_addr_i = ta; d_we_i = tw; d_wdata_i = twd;
      end
      i_rready_i = ($urandom_range(0, 3) != 0);
      d_rready_i = ($urandom_range(0, 3) != 0);
      #4;
      i_fire = i_valid_i && i_ready_o;
      d_fire = d_valid_i && d_ready_o;
    end
    @(negedge clk_i);
    i_valid_i = 0; d_valid_i = 0; i_rready_i = 1; d_rready_i = 1;
    repeat (20) @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
